// File: rtl/bus_split_arbiter.sv
// Central arbiter for Bus A: shares the bus between two initiators and the
// split-capable bridge target, parks an initiator whose transfer was split,
// and aborts a parked split that waits too long for the bridge to return.
module bus_split_arbiter #(
    parameter logic        ROUND_ROBIN   = 1'b1,
    parameter logic [15:0] SPLIT_TIMEOUT = 16'd4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init1_req,
    input  logic       init2_req,
    input  logic       split_target_req,
    input  logic       split_ack,
    input  logic       trans_done,
    output logic       init1_grant,
    output logic       init2_grant,
    output logic       split_target_grant,
    output logic [1:0] master_sel,
    output logic [1:0] split_owner,
    output logic       split_pending,
    output logic       split_timeout
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        OWN_I1      = 2'd1,
        OWN_I2      = 2'd2,
        SPLIT_SERVE = 2'd3
    } state_e;

    localparam logic [1:0]  OWNER_NONE = 2'b00;
    localparam logic [1:0]  OWNER_I1   = 2'b01;
    localparam logic [1:0]  OWNER_I2   = 2'b10;
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic [1:0]  owner_q, owner_d;
    logic        last_q, last_d;      // 0: init1 won last, 1: init2 won last
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_hit_s;
    logic        cnt_run_s;
    logic        elig1_s, elig2_s;
    logic        i1_grant_q, i2_grant_q, st_grant_q, timeout_q;
    logic [1:0]  sel_q;

    // Next-state, split bookkeeping and timeout counter logic.
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        owner_d       = owner_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        cnt_run_s     = pend_q && (state_q != SPLIT_SERVE);
        timeout_hit_s = cnt_run_s && (cnt_q == (SPLIT_TIMEOUT - 16'd1));
        // The parked initiator may not re-enter until its split is resolved.
        elig1_s       = init1_req && !(pend_q && (owner_q == OWNER_I1));
        elig2_s       = init2_req && !(pend_q && (owner_q == OWNER_I2));

        if (cnt_run_s && !timeout_hit_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (timeout_hit_s) begin
            pend_d  = 1'b0;
            owner_d = OWNER_NONE;
        end else begin
            pend_d  = pend_q;
        end

        case (state_q)
            IDLE: begin
                // A timeout in the same cycle beats the bridge's re-request.
                if (pend_q && split_target_req && !timeout_hit_s) begin
                    state_d = SPLIT_SERVE;
                end else if (elig1_s && elig2_s) begin
                    if (ROUND_ROBIN && !last_q) begin
                        state_d = OWN_I2;
                    end else begin
                        state_d = OWN_I1;
                    end
                end else if (elig1_s) begin
                    state_d = OWN_I1;
                end else if (elig2_s) begin
                    state_d = OWN_I2;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_I1, OWN_I2: begin
                // Only one split may be outstanding; a second split_ack is ignored.
                if (split_ack && !pend_q) begin
                    pend_d  = 1'b1;
                    owner_d = (state_q == OWN_I1) ? OWNER_I1 : OWNER_I2;
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end else if (trans_done) begin
                    state_d = IDLE;
                end else if (((state_q == OWN_I1) && !init1_req) ||
                             ((state_q == OWN_I2) && !init2_req)) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            SPLIT_SERVE: begin
                if (trans_done || !split_target_req) begin
                    pend_d  = 1'b0;
                    owner_d = OWNER_NONE;
                    state_d = IDLE;
                end else begin
                    state_d = SPLIT_SERVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q == IDLE) && (state_d == OWN_I1)) begin
            last_d = 1'b0;
        end else if ((state_q == IDLE) && (state_d == OWN_I2)) begin
            last_d = 1'b1;
        end else begin
            last_d = last_q;
        end
    end

    // State, bookkeeping and registered output updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            owner_q    <= OWNER_NONE;
            last_q     <= 1'b1;
            cnt_q      <= 16'd0;
            i1_grant_q <= 1'b0;
            i2_grant_q <= 1'b0;
            st_grant_q <= 1'b0;
            sel_q      <= 2'b00;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            i1_grant_q <= (state_d == OWN_I1);
            i2_grant_q <= (state_d == OWN_I2);
            st_grant_q <= (state_d == SPLIT_SERVE);
            sel_q      <= state_d;
            timeout_q  <= timeout_hit_s;
        end
    end

    assign init1_grant        = i1_grant_q;
    assign init2_grant        = i2_grant_q;
    assign split_target_grant = st_grant_q;
    assign master_sel         = sel_q;
    assign split_owner        = owner_q;
    assign split_pending      = pend_q;
    assign split_timeout      = timeout_q;

endmodule
